// File: rtl/lcd_pkg.sv
// Shared types and default 50 MHz timing for the HD44780 byte write engine.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_EN_HIGH = 3'd2,
    ST_HOLD    = 3'd3,
    ST_EXEC    = 3'd4,
    ST_DONE    = 3'd5
  } lcd_state_e;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;

  localparam int unsigned T_SETUP_DEF     = 4;
  localparam int unsigned T_EN_DEF        = 16;
  localparam int unsigned T_HOLD_DEF      = 4;
  localparam int unsigned T_EXEC_DEF      = 2000;
  localparam int unsigned T_EXEC_LONG_DEF = 82000;
  localparam int unsigned CNT_W_DEF       = 17;

  // Clear (0x01) and home (0x02/0x03) commands need the long execution wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return (rs == 1'b0) && (data[7:1] == CMD_HOME[7:1] || data == CMD_CLEAR);
  endfunction

endpackage

// File: rtl/lcd_write_engine.sv
// Byte-level HD44780 write engine: setup, enable pulse, hold and execution wait,
// then a one-cycle done pulse. Write-only bus.
module lcd_write_engine
  import lcd_pkg::*;
#(
  parameter int unsigned T_SETUP     = T_SETUP_DEF,
  parameter int unsigned T_EN        = T_EN_DEF,
  parameter int unsigned T_HOLD      = T_HOLD_DEF,
  parameter int unsigned T_EXEC      = T_EXEC_DEF,
  parameter int unsigned T_EXEC_LONG = T_EXEC_LONG_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic       iCLK_50MHZ,
  input  logic       iRST_N,
  input  logic       iSTART,
  input  logic [7:0] iDATA,
  input  logic       iRS,
  output logic       oBUSY,
  output logic       oDONE,
  output logic [7:0] oLCD_DATA,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_EN
);

  lcd_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] phase_last;
  logic [7:0]       data_q, data_d;
  logic             rs_q, rs_d;
  logic             long_q, long_d;
  logic             busy_q, done_q, en_q;

  // Last counter value of the current timed phase.
  always_comb begin
    phase_last = '0;
    unique case (state_q)
      ST_SETUP:   phase_last = CNT_W'(T_SETUP - 1);
      ST_EN_HIGH: phase_last = CNT_W'(T_EN - 1);
      ST_HOLD:    phase_last = CNT_W'(T_HOLD - 1);
      ST_EXEC:    phase_last = long_q ? CNT_W'(T_EXEC_LONG - 1) : CNT_W'(T_EXEC - 1);
      default:    phase_last = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    rs_d    = rs_q;
    long_d  = long_q;
    unique case (state_q)
      ST_IDLE: begin
        if (iSTART) begin
          data_d  = iDATA;
          rs_d    = iRS;
          long_d  = is_long_cmd(iRS, iDATA);
          cnt_d   = '0;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP, ST_EN_HIGH, ST_HOLD, ST_EXEC: begin
        if (cnt_q == phase_last) begin
          cnt_d = '0;
          unique case (state_q)
            ST_SETUP:   state_d = ST_EN_HIGH;
            ST_EN_HIGH: state_d = ST_HOLD;
            ST_HOLD:    state_d = ST_EXEC;
            default:    state_d = ST_DONE;
          endcase
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they align with state_q.
  always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      data_q  <= 8'h00;
      rs_q    <= 1'b0;
      long_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
      long_q  <= long_d;
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= (state_d == ST_DONE);
      en_q    <= (state_d == ST_EN_HIGH);
    end
  end

  assign oBUSY     = busy_q;
  assign oDONE     = done_q;
  assign oLCD_DATA = data_q;
  assign LCD_RS    = rs_q;
  assign LCD_RW    = 1'b0;
  assign LCD_EN    = en_q;

endmodule

// File: tb/tb_lcd_write_engine.sv
// Directed bench for lcd_write_engine with shortened timing (2/3/2/5/20 cycles).
module tb_lcd_write_engine;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] data;
  logic       rs;
  logic       busy, done, lcd_rs, lcd_rw, lcd_en;
  logic [7:0] lcd_data;

  int n_checks = 0;
  int n_fail   = 0;

  int done_first, done_cnt, en_first, en_last, en_cnt, busy_drop, data_bad, rw_bad;
  int inj_cycle = -1;

  lcd_write_engine #(
    .T_SETUP(2), .T_EN(3), .T_HOLD(2), .T_EXEC(5), .T_EXEC_LONG(20), .CNT_W(17)
  ) dut (
    .iCLK_50MHZ(clk),
    .iRST_N    (rst_n),
    .iSTART    (start),
    .iDATA     (data),
    .iRS       (rs),
    .oBUSY     (busy),
    .oDONE     (done),
    .oLCD_DATA (lcd_data),
    .LCD_RS    (lcd_rs),
    .LCD_RW    (lcd_rw),
    .LCD_EN    (lcd_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Issue one start pulse; returns just after the accepting edge with changed inputs.
  task automatic issue(input logic [7:0] d, input logic r);
    @(negedge clk);
    start = 1'b1;
    data  = d;
    rs    = r;
    @(posedge clk);
    #1;
    start = 1'b0;
    data  = ~d;
    rs    = ~r;
  endtask

  // Watch ncyc cycles (cycle 0 = first SETUP cycle), sampling on falling edges.
  task automatic observe(input int ncyc, input logic [7:0] exp_d, input logic exp_rs);
    done_first = -1; done_cnt = 0; en_first = -1; en_last = -1; en_cnt = 0;
    busy_drop = -1; data_bad = 0; rw_bad = 0;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      if (done) begin
        if (done_first < 0) done_first = k;
        done_cnt++;
      end
      if (lcd_en) begin
        if (en_first < 0) en_first = k;
        en_last = k;
        en_cnt++;
      end
      if (!busy && busy_drop < 0) busy_drop = k;
      if (lcd_data !== exp_d || lcd_rs !== exp_rs) data_bad++;
      if (lcd_rw !== 1'b0) rw_bad++;
      if (k == inj_cycle) begin
        start = 1'b1; data = 8'h55; rs = 1'b0;
      end else if (k == inj_cycle + 1) begin
        start = 1'b0;
      end
    end
  endtask

  int accepts, rise_at[3], widths_bad, pulses, run, dones6;
  logic prev_busy, prev_en;

  initial begin
    rst_n = 1'b0; start = 1'b0; data = 8'h00; rs = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_en",   32'(lcd_en), 32'd0);
    check("rst_rs",   32'(lcd_rs), 32'd0);
    check("rst_data", 32'(lcd_data), 32'h00);
    check("rst_rw",   32'(lcd_rw), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Data write 0x41
    issue(8'h41, 1'b1);
    observe(16, 8'h41, 1'b1);
    check("wr41_data",      32'(data_bad), 32'd0);
    check("wr41_en_first",  32'(en_first), 32'd2);
    check("wr41_en_last",   32'(en_last), 32'd4);
    check("wr41_en_cnt",    32'(en_cnt), 32'd3);
    check("wr41_done_at",   32'(done_first), 32'd12);
    check("wr41_done_cnt",  32'(done_cnt), 32'd1);
    check("wr41_busy_drop", 32'(busy_drop), 32'd13);
    check("wr41_rw",        32'(rw_bad), 32'd0);

    // Clear command: long wait
    issue(8'h01, 1'b0);
    observe(32, 8'h01, 1'b0);
    check("clr_done_at",   32'(done_first), 32'd27);
    check("clr_done_cnt",  32'(done_cnt), 32'd1);
    check("clr_busy_drop", 32'(busy_drop), 32'd28);
    check("clr_data",      32'(data_bad), 32'd0);

    // Home command 0x03 also long
    issue(8'h03, 1'b0);
    observe(32, 8'h03, 1'b0);
    check("home_done_at", 32'(done_first), 32'd27);

    // 0x01 as data: short wait
    issue(8'h01, 1'b1);
    observe(16, 8'h01, 1'b1);
    check("d01_done_at", 32'(done_first), 32'd12);

    // 0x00 command: short wait
    issue(8'h00, 1'b0);
    observe(16, 8'h00, 1'b0);
    check("c00_done_at", 32'(done_first), 32'd12);

    // Busy rejection
    inj_cycle = 2;
    issue(8'h41, 1'b1);
    observe(20, 8'h41, 1'b1);
    inj_cycle = -1;
    check("busy_rej_data", 32'(data_bad), 32'd0);
    check("busy_rej_done_cnt", 32'(done_cnt), 32'd1);
    check("busy_rej_done_at", 32'(done_first), 32'd12);
    check("busy_rej_idle", 32'(busy), 32'd0);

    // Reset mid-operation during EN_HIGH
    issue(8'h41, 1'b1);
    repeat (3) @(negedge clk);
    check("midrst_en_before", 32'(lcd_en), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_en_now",   32'(lcd_en), 32'd0);
    check("midrst_busy_now", 32'(busy), 32'd0);
    done_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("midrst_no_done", 32'(done_cnt), 32'd0);
    issue(8'h30, 1'b0);
    observe(16, 8'h30, 1'b0);
    check("after_rst_done_at", 32'(done_first), 32'd12);
    check("after_rst_data",    32'(data_bad), 32'd0);

    // iSTART held high: back-to-back writes
    @(negedge clk);
    start = 1'b1; data = 8'h48; rs = 1'b1;
    accepts = 0; widths_bad = 0; pulses = 0; run = 0; dones6 = 0;
    prev_busy = 1'b0; prev_en = 1'b0;
    for (int i = 0; i < 3; i++) rise_at[i] = -1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (busy && !prev_busy) begin
        if (accepts < 3) rise_at[accepts] = k;
        accepts++;
      end
      if (done) dones6++;
      if (lcd_en) run++;
      if (!lcd_en && prev_en) begin
        pulses++;
        if (run != 3) widths_bad++;
        run = 0;
      end
      prev_busy = busy;
      prev_en = lcd_en;
      if (k == 38) start = 1'b0;
    end
    check("b2b_accepts", 32'(accepts), 32'd3);
    check("b2b_rise0",   32'(rise_at[0]), 32'd0);
    check("b2b_rise1",   32'(rise_at[1]), 32'd14);
    check("b2b_rise2",   32'(rise_at[2]), 32'd28);
    check("b2b_dones",   32'(dones6), 32'd3);
    check("b2b_pulses",  32'(pulses), 32'd3);
    check("b2b_widths",  32'(widths_bad), 32'd0);
    check("final_rw",    32'(lcd_rw), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
